// File: rtl/energy_frame_sequencer.sv
// Frame sequencer for the FFT-energy datapath: ping-pongs the magnitude BRAM banks,
// runs the ready/start/done handshake with the energy block and aborts stalled frames.
module energy_frame_sequencer #(
  parameter int ACK_TIMEOUT = 16,
  parameter int RUN_TIMEOUT = 32768,
  parameter int CNT_W       = 16,
  parameter int COLOR_W     = 84
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fft_frame_done,
  input  logic               energy_start,
  input  logic               energy_done,
  input  logic [COLOR_W-1:0] color_in,
  output logic               energy_ready,
  output logic               energy_reset,
  output logic               bank_wr_sel,
  output logic               bank_rd_sel,
  output logic               busy,
  output logic [COLOR_W-1:0] color_out,
  output logic               color_valid,
  output logic [CNT_W-1:0]   frame_count,
  output logic [CNT_W-1:0]   drop_count,
  output logic               timeout_err
);

  localparam int TIMER_MAX = (ACK_TIMEOUT > RUN_TIMEOUT) ? ACK_TIMEOUT : RUN_TIMEOUT;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] ACK_LAST = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] RUN_LAST = TIMER_W'(RUN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_LATCH,
    S_ABORT
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               pending;
  logic               done_q;

  logic ack;
  logic done_rise;
  logic frame_lost;
  logic drop_full;

  // Either a raised start level or a dropped done level means the energy block took the frame.
  assign ack        = energy_start | ~energy_done;
  assign done_rise  = energy_done & ~done_q;
  assign drop_full  = &drop_count;
  // A new frame landing while an unprocessed one waits in the same bank overwrites it.
  assign frame_lost = fft_frame_done & pending;

  assign bank_rd_sel = ~bank_wr_sel;

  // NOTE: reset is synchronous and sits first in the if-chain so it beats every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      timer        <= '0;
      pending      <= 1'b0;
      // NOTE: done_q resets to the idle level of energy_done so no false rising edge appears.
      done_q       <= 1'b1;
      energy_ready <= 1'b0;
      energy_reset <= 1'b0;
      bank_wr_sel  <= 1'b0;
      busy         <= 1'b0;
      color_out    <= '0;
      color_valid  <= 1'b0;
      frame_count  <= '0;
      drop_count   <= '0;
      timeout_err  <= 1'b0;
    end else begin
      done_q       <= energy_done;
      energy_reset <= 1'b0;
      color_valid  <= 1'b0;

      if (frame_lost && !drop_full) begin
        drop_count <= drop_count + CNT_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (fft_frame_done || pending) begin
            bank_wr_sel  <= ~bank_wr_sel;
            pending      <= 1'b0;
            timer        <= '0;
            energy_ready <= 1'b1;
            busy         <= 1'b1;
            state        <= S_ARM;
          end
        end

        S_ARM: begin
          if (fft_frame_done) begin
            pending <= 1'b1;
          end
          if (ack) begin
            energy_ready <= 1'b0;
            timer        <= '0;
            state        <= S_RUN;
          end else if (timer == ACK_LAST) begin
            energy_ready <= 1'b0;
            energy_reset <= 1'b1;
            busy         <= 1'b0;
            timer        <= '0;
            state        <= S_ABORT;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        S_RUN: begin
          if (fft_frame_done) begin
            pending <= 1'b1;
          end
          if (done_rise) begin
            timer <= '0;
            state <= S_LATCH;
          end else if (timer == RUN_LAST) begin
            energy_reset <= 1'b1;
            busy         <= 1'b0;
            timer        <= '0;
            state        <= S_ABORT;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        S_LATCH: begin
          color_out   <= color_in;
          color_valid <= 1'b1;
          frame_count <= frame_count + CNT_W'(1);
          timer       <= '0;
          // A frame arriving this very cycle is simply the next one to process.
          if (fft_frame_done || pending) begin
            bank_wr_sel  <= ~bank_wr_sel;
            pending      <= 1'b0;
            energy_ready <= 1'b1;
            state        <= S_ARM;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_ABORT: begin
          if (fft_frame_done) begin
            pending <= 1'b1;
          end
          timeout_err <= 1'b1;
          timer       <= '0;
          state       <= S_IDLE;
        end

        default: begin
          energy_ready <= 1'b0;
          busy         <= 1'b0;
          timer        <= '0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_energy_frame_sequencer.sv
// Directed bench for energy_frame_sequencer: single frame, back-to-back drops,
// LATCH-coincident frame, ack timeout, run stall and mid-frame reset.
module tb_energy_frame_sequencer;

  localparam int ACK_TIMEOUT = 16;
  localparam int RUN_TIMEOUT = 32768;
  localparam int CNT_W       = 16;
  localparam int COLOR_W     = 84;

  localparam logic [COLOR_W-1:0] C1 = 84'hFFF_0123_4567_89AB_CDEF_01;
  localparam logic [COLOR_W-1:0] C2 = 84'h800_1111_2222_3333_4444_55;
  localparam logic [COLOR_W-1:0] C3 = 84'h00A_BCDE_F012_3456_789A_BC;
  localparam logic [COLOR_W-1:0] C4 = 84'h5A5_A5A5_A5A5_A5A5_A5A5_A5;
  localparam logic [COLOR_W-1:0] C5 = 84'h3C3_C3C3_C3C3_C3C3_C3C3_C3;
  localparam logic [COLOR_W-1:0] C6 = 84'h777_0000_FFFF_0000_FFFF_77;

  logic               clock = 1'b0;
  logic               reset;
  logic               fft_frame_done;
  logic               energy_start;
  logic               energy_done;
  logic [COLOR_W-1:0] color_in;
  logic               energy_ready;
  logic               energy_reset;
  logic               bank_wr_sel;
  logic               bank_rd_sel;
  logic               busy;
  logic [COLOR_W-1:0] color_out;
  logic               color_valid;
  logic [CNT_W-1:0]   frame_count;
  logic [CNT_W-1:0]   drop_count;
  logic               timeout_err;

  int check_count = 0;
  int pass_count  = 0;

  energy_frame_sequencer #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .RUN_TIMEOUT(RUN_TIMEOUT),
    .CNT_W      (CNT_W),
    .COLOR_W    (COLOR_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .fft_frame_done(fft_frame_done),
    .energy_start  (energy_start),
    .energy_done   (energy_done),
    .color_in      (color_in),
    .energy_ready  (energy_ready),
    .energy_reset  (energy_reset),
    .bank_wr_sel   (bank_wr_sel),
    .bank_rd_sel   (bank_rd_sel),
    .busy          (busy),
    .color_out     (color_out),
    .color_valid   (color_valid),
    .frame_count   (frame_count),
    .drop_count    (drop_count),
    .timeout_err   (timeout_err)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic pulse_frame();
    fft_frame_done = 1'b1;
    tick();
    fft_frame_done = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    fft_frame_done = 1'b0;
    energy_start   = 1'b0;
    energy_done    = 1'b1;
    color_in       = '0;
    repeat (3) tick();

    // Reset state
    check("rst_ready", energy_ready, 0);
    check("rst_ereset", energy_reset, 0);
    check("rst_wr", bank_wr_sel, 0);
    check("rst_rd", bank_rd_sel, 1);
    check("rst_busy", busy, 0);
    check("rst_color", color_out, 0);
    check("rst_valid", color_valid, 0);
    check("rst_fc", frame_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_terr", timeout_err, 0);
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Single frame, ack two cycles after ready, done 100 cycles later
    pulse_frame();
    check("t1_wr", bank_wr_sel, 1);
    check("t1_rd", bank_rd_sel, 0);
    check("t1_ready", energy_ready, 1);
    check("t1_busy", busy, 1);
    tick();
    check("t1_ready_hold", energy_ready, 1);
    energy_start = 1'b1;
    energy_done  = 1'b0;
    tick();
    check("t1_ready_drop", energy_ready, 0);
    check("t1_run_busy", busy, 1);
    repeat (99) tick();
    check("t1_run_valid", color_valid, 0);
    color_in     = C1;
    energy_start = 1'b0;
    energy_done  = 1'b1;
    tick();
    check("t1_latch_valid", color_valid, 0);
    check("t1_latch_busy", busy, 1);
    tick();
    check("t1_valid", color_valid, 1);
    check("t1_color", color_out, C1);
    check("t1_fc", frame_count, 1);
    check("t1_idle", busy, 0);
    check("t1_ready_idle", energy_ready, 0);
    tick();
    check("t1_valid_pulse", color_valid, 0);

    // Back-to-back: three frames arrive during one RUN
    pulse_frame();
    check("t2_wr", bank_wr_sel, 0);
    energy_start = 1'b1;
    energy_done  = 1'b0;
    tick();
    pulse_frame();
    tick();
    pulse_frame();
    pulse_frame();
    check("t2_drop", drop_count, 2);
    check("t2_no_swap", bank_wr_sel, 0);
    check("t2_busy", busy, 1);
    color_in     = C2;
    energy_start = 1'b0;
    energy_done  = 1'b1;
    tick();
    tick();
    check("t2_valid", color_valid, 1);
    check("t2_color", color_out, C2);
    check("t2_fc", frame_count, 2);
    check("t2_swap", bank_wr_sel, 1);
    check("t2_rearm", energy_ready, 1);
    check("t2_drop_hold", drop_count, 2);
    energy_start = 1'b1;
    energy_done  = 1'b0;
    tick();
    color_in     = C3;
    energy_start = 1'b0;
    energy_done  = 1'b1;
    tick();
    tick();
    check("t2b_fc", frame_count, 3);
    check("t2b_color", color_out, C3);
    check("t2b_idle", busy, 0);

    // Frame arrives exactly in the LATCH cycle
    pulse_frame();
    check("t3_wr", bank_wr_sel, 0);
    energy_start = 1'b1;
    energy_done  = 1'b0;
    tick();
    color_in     = C4;
    energy_start = 1'b0;
    energy_done  = 1'b1;
    tick();
    pulse_frame();
    check("t3_drop", drop_count, 2);
    check("t3_swap", bank_wr_sel, 1);
    check("t3_rearm", energy_ready, 1);
    check("t3_fc", frame_count, 4);
    check("t3_color", color_out, C4);
    energy_start = 1'b1;
    energy_done  = 1'b0;
    tick();
    color_in     = C5;
    energy_start = 1'b0;
    energy_done  = 1'b1;
    tick();
    tick();
    check("t3b_fc", frame_count, 5);
    check("t3b_idle", busy, 0);

    // No ack: ABORT after ACK_TIMEOUT cycles in ARM
    pulse_frame();
    check("t4_wr", bank_wr_sel, 0);
    repeat (ACK_TIMEOUT - 1) tick();
    check("t4_last_ready", energy_ready, 1);
    check("t4_last_ereset", energy_reset, 0);
    tick();
    check("t4_ereset", energy_reset, 1);
    check("t4_abort_busy", busy, 0);
    check("t4_abort_ready", energy_ready, 0);
    tick();
    check("t4_ereset_pulse", energy_reset, 0);
    check("t4_terr", timeout_err, 1);
    check("t4_fc", frame_count, 5);
    check("t4_color", color_out, C5);

    // Run stall: ABORT after RUN_TIMEOUT cycles in RUN, then a good frame
    pulse_frame();
    check("t5_wr", bank_wr_sel, 1);
    energy_start = 1'b1;
    energy_done  = 1'b0;
    tick();
    repeat (RUN_TIMEOUT - 1) tick();
    check("t5_last_busy", busy, 1);
    check("t5_last_ereset", energy_reset, 0);
    tick();
    check("t5_ereset", energy_reset, 1);
    energy_start = 1'b0;
    energy_done  = 1'b1;
    tick();
    check("t5_color_hold", color_out, C5);
    check("t5_fc_hold", frame_count, 5);
    check("t5_idle", busy, 0);
    pulse_frame();
    check("t5b_wr", bank_wr_sel, 0);
    energy_start = 1'b1;
    energy_done  = 1'b0;
    tick();
    color_in     = C6;
    energy_start = 1'b0;
    energy_done  = 1'b1;
    tick();
    tick();
    check("t5b_fc", frame_count, 6);
    check("t5b_color", color_out, C6);
    check("t5b_terr", timeout_err, 1);

    // Reset in the middle of RUN, then a late done rise
    pulse_frame();
    check("t6_wr", bank_wr_sel, 1);
    energy_start = 1'b1;
    energy_done  = 1'b0;
    repeat (6) tick();
    check("t6_run_busy", busy, 1);
    reset = 1'b1;
    tick();
    check("t6_busy", busy, 0);
    check("t6_ready", energy_ready, 0);
    check("t6_wr_rst", bank_wr_sel, 0);
    check("t6_rd_rst", bank_rd_sel, 1);
    check("t6_color", color_out, 0);
    check("t6_fc", frame_count, 0);
    check("t6_drop", drop_count, 0);
    check("t6_terr", timeout_err, 0);
    reset        = 1'b0;
    energy_start = 1'b0;
    energy_done  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_late_valid", color_valid, 0);
    end
    check("t6_late_fc", frame_count, 0);
    check("t6_late_busy", busy, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
